// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   - uart_state_e : receiver deframer states
//   - DATA_BITS    : payload bits per frame (8N1)
//   - CNT_W        : width of the per-bit clock counter
//   - majority3    : 2-of-3 vote used by the optional sample filter
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    // 2-of-3 majority vote
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clk domain.
// Two-flop synchroniser followed by a one-cycle history flop for edge
// detection. With UART_RX_MAJORITY_EN defined, a second history flop is
// added and `sample` is the 2-of-3 vote of the last three synchronised
// values; otherwise `sample` is the synchronised line itself.
// Ports:
//   clk       in  system clock
//   reset_n   in  asynchronous active-low reset (all flops reset to idle-high)
//   rx_line   in  raw serial input
//   rx_s      out synchronised line
//   rx_s_prev out rx_s delayed by one clock
//   sample    out value used at every bit sample point
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic rx_line,
    output logic rx_s,
    output logic rx_s_prev,
    output logic sample
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
`ifdef UART_RX_MAJORITY_EN
    logic prev2_r;
`endif

    // Synchroniser and sample history; reset to the idle-high line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r  <= 1'b1;
            sync_r  <= 1'b1;
            prev_r  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            prev2_r <= 1'b1;
`endif
        end else begin
            meta_r  <= rx_line;
            sync_r  <= meta_r;
            prev_r  <= sync_r;
`ifdef UART_RX_MAJORITY_EN
            prev2_r <= prev_r;
`endif
        end
    end

    assign rx_s      = sync_r;
    assign rx_s_prev = prev_r;
`ifdef UART_RX_MAJORITY_EN
    assign sample    = majority3(sync_r, prev_r, prev2_r);
`else
    assign sample    = sync_r;
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver.
// Detects the start edge on the synchronised line, re-checks the start bit
// at half a bit period, samples each data bit at mid-bit (LSB first) and
// checks the stop bit. Completed bytes go to a one-entry valid/ready buffer.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority at sample points).
// CLKS_PER_BIT must be >= 8 and < 65536.
// Ports:
//   clk          in  system clock, rising edge
//   reset_n      in  asynchronous active-low reset
//   rx_line      in  serial input, idle high
//   rx_ready     in  consumer accepts byte when rx_valid && rx_ready
//   rx_data      out received byte, stable while rx_valid && !rx_ready
//   rx_valid     out byte present in the output buffer
//   rx_busy      out receiver is not in IDLE
//   rx_frame_err out one-cycle pulse: stop bit sampled low
//   rx_overrun   out one-cycle pulse: byte completed while buffer full (dropped)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 19200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_line,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic rx_s;
    logic rx_s_prev;
    logic sample_s;

    uart_state_e          state_r;
    logic [CNT_W-1:0]     clk_count_r;
    logic [2:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 rx_busy_r;
    logic                 rx_frame_err_r;
    logic                 rx_overrun_r;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_line   (rx_line),
        .rx_s      (rx_s),
        .rx_s_prev (rx_s_prev),
        .sample    (sample_s)
    );

    // Deframing FSM together with the output buffer and status pulses.
    // rx_busy is updated on every transition so it tracks state_r != IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            clk_count_r    <= CNT_ZERO;
            bit_idx_r      <= 3'd0;
            shift_r        <= {DATA_BITS{1'b0}};
            rx_data_r      <= {DATA_BITS{1'b0}};
            rx_valid_r     <= 1'b0;
            rx_busy_r      <= 1'b0;
            rx_frame_err_r <= 1'b0;
            rx_overrun_r   <= 1'b0;
        end else begin
            rx_frame_err_r <= 1'b0;
            rx_overrun_r   <= 1'b0;

            // Consumer handshake; a load in STOP below overrides this
            if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    clk_count_r <= CNT_ZERO;
                    if (rx_s_prev && !rx_s) begin
                        state_r   <= START;
                        rx_busy_r <= 1'b1;
                    end
                end

                START: begin
                    if (clk_count_r == HALF_M1) begin
                        clk_count_r <= CNT_ZERO;
                        if (!sample_s) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= DATA;
                        end else begin
                            // Line already high again: treat as a glitch
                            state_r   <= IDLE;
                            rx_busy_r <= 1'b0;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end

                DATA: begin
                    if (clk_count_r == BIT_M1) begin
                        clk_count_r        <= CNT_ZERO;
                        shift_r[bit_idx_r] <= sample_s;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end

                STOP: begin
                    if (clk_count_r == BIT_M1) begin
                        clk_count_r <= CNT_ZERO;
                        if (sample_s) begin
                            // Leave at mid-stop so the next start edge has half a bit of margin
                            state_r   <= IDLE;
                            rx_busy_r <= 1'b0;
                            if (!rx_valid_r || rx_ready) begin
                                rx_data_r  <= shift_r;
                                rx_valid_r <= 1'b1;
                            end else begin
                                rx_overrun_r <= 1'b1;
                            end
                        end else begin
                            rx_frame_err_r <= 1'b1;
                            state_r        <= WAIT_IDLE;
                        end
                    end else begin
                        clk_count_r <= clk_count_r + CNT_ONE;
                    end
                end

                WAIT_IDLE: begin
                    // Hold off new starts (e.g. during a break) until the line is seen high
                    clk_count_r <= CNT_ZERO;
                    if (rx_s) begin
                        state_r   <= IDLE;
                        rx_busy_r <= 1'b0;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    clk_count_r <= CNT_ZERO;
                    rx_busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_busy      = rx_busy_r;
    assign rx_frame_err = rx_frame_err_r;
    assign rx_overrun   = rx_overrun_r;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized self-checking bench for uart_receiver.
// A behavioural line driver produces 8N1 frames; expected bytes, error and
// overrun counts are kept in a queue and counters and compared against the
// outputs sampled on the falling clock edge.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_line = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_overrun;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_start = 0;
    int rise_cyc = 0;
    int got_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rdy_mode = 0;
    bit glitch_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (100000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_line      (rx_line),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer readiness driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor / scoreboard
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (rx_valid && !pv) rise_cyc = cyc;
                if (pv && !pr && rx_valid) chk("hold", rx_data, pd);
                if (rx_frame_err) fe_cnt++;
                if (rx_overrun) ov_cnt++;
                if (rx_valid && rx_ready) begin
                    got_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("spurious", 32'd1, 32'd0);
                    end else begin
                        chk("data", rx_data, exp_q.pop_front());
                    end
                end
            end
            pv = rx_valid;
            pr = rx_ready;
            pd = rx_data;
        end
    end

    // Drive one frame: start, 8 data bits LSB first, stop
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                if (i == 0 && c == 0) t_start = cyc;
                rx_line = fr[i];
`ifdef UART_RX_MAJORITY_EN
                if (glitch_en && i > 0 && i < 9 && c == CPB / 2) rx_line = ~fr[i];
`endif
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int f0;
        int lat;
        logic [7:0] b;

        // Reset with a toggling line
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            rx_line = ~rx_line;
        end
        @(negedge clk);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_ferr", rx_frame_err, 1'b0);
        chk("rst_ovr", rx_overrun, 1'b0);
        rx_line = 1'b1;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(10);
        chk("idle_busy", rx_busy, 1'b0);

        // Single frame with latency measurement
        rdy_mode = 1;
        c0 = got_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cycles(CPB);
        lat = rise_cyc - t_start;
        chk("latency_win", 32'((lat >= 152) && (lat <= 158)), 32'd1);
        chk("single_cnt", got_cnt - c0, 32'd1);
        chk("single_flags", fe_cnt + ov_cnt, 32'd0);

        // Framing error followed by a break of 20 bit times
        c0 = got_cnt;
        send_frame(8'h3C, 1'b0);
        wait_cycles(20 * CPB);
        chk("brk_busy", rx_busy, 1'b1);
        chk("fe_cnt", fe_cnt, 32'd1);
        chk("fe_novalid", got_cnt - c0, 32'd0);
        rx_line = 1'b1;
        wait_cycles(6);
        chk("brk_release", rx_busy, 1'b0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_cycles(CPB);
        chk("after_fe_cnt", got_cnt - c0, 32'd1);

        // Overrun: buffer held full while a second byte arrives
        rdy_mode = 0;
        wait_cycles(2);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(CPB);
        chk("ovr_valid", rx_valid, 1'b1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_cnt", ov_cnt, 32'd1);
        @(posedge clk);
        rdy_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("accept_drop", rx_valid, 1'b0);

        // False start: quarter-bit low pulse
        c0 = got_cnt;
        f0 = fe_cnt + ov_cnt;
        @(posedge clk);
        #1;
        rx_line = 1'b0;
        wait_cycles(CPB / 4);
        rx_line = 1'b1;
        wait_cycles(3 * CPB);
        chk("fs_busy", rx_busy, 1'b0);
        chk("fs_valid", got_cnt - c0, 32'd0);
        chk("fs_flags", fe_cnt + ov_cnt - f0, 32'd0);

        // Loopback-style stream: corner bytes then random bytes, random gaps
        rdy_mode = 2;
        glitch_en = 1'b1;
        c0 = got_cnt;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       b = 8'h00;
                1:       b = 8'hFF;
                2:       b = 8'h55;
                3:       b = 8'hAA;
                default: b = 8'($urandom);
            endcase
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            wait_cycles($urandom_range(0, 3));
        end
        rdy_mode = 1;
        wait_cycles(3 * CPB);
        chk("stream_cnt", got_cnt - c0, 32'd24);
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_fe", fe_cnt, 32'd1);
        chk("final_ovr", ov_cnt, 32'd1);
        chk("final_busy", rx_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
